pxs_multi_ball_overlay: RTL and testbench

Parametrised successor to the single bouncing-ball overlay. Draws up to 4 independently moving square balls on the pixel stream. All balls share one speed, adjustable at run time. Supports pause and emits a bounce pulse for a sound block. Sits inline in the Pxs chain (Pxs.vh stream layout, `XC/`YC/`RGB/`VGA fields), after the timing generator and before the VGA output stage.

---
 rtl/pxs_multi_ball_overlay.sv | 168 ++++++++++++++++
 tb/tb_pxs_multi_ball_overlay.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pxs_multi_ball_overlay.sv
// Inline Pxs overlay: draws up to four bouncing square balls with a shared, adjustable speed.
// Optional macro PXS_BALL_COLLIDE_EN adds ball-to-ball collision handling.
module pxs_multi_ball_overlay #(
  parameter int          N_BALLS     = 2,
  parameter int          SIZE_BALL   = 16,
  parameter int          INIT_SPEED  = 1,
  parameter int          MAX_SPEED   = 8,
  parameter int          BORDER      = 0,
  parameter int          VISIBLECOLS = 640,
  parameter int          VISIBLEROWS = 480,
  parameter logic [11:0] BALL_COLORS = 12'b011_110_010_101
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic [25:0] RGBStr_i,
  input  logic        inc_vel,
  input  logic        dec_vel,
  input  logic        pause,
  output logic [25:0] RGBStr_o,
  output logic        bounce
);

  // Stream layout: RGB [25:23], blank [22], XC [21:11], YC [10:0]; bits [22:0] form the VGA field.
  localparam int RGB_LO = 23;
  localparam int VGA_HI = 22;
  localparam int XC_LO  = 11;
  localparam int W      = 11;

  localparam logic [W-1:0] SZ    = W'(SIZE_BALL);
  localparam logic [W-1:0] X_MIN = W'(BORDER);
  localparam logic [W-1:0] Y_MIN = W'(BORDER);
  localparam logic [W-1:0] X_MAX = W'(VISIBLECOLS - SIZE_BALL - BORDER);
  localparam logic [W-1:0] Y_MAX = W'(VISIBLEROWS - SIZE_BALL - BORDER);
  localparam logic [W-1:0] X_RST = W'((VISIBLECOLS - SIZE_BALL) / 4);
  localparam logic [W-1:0] Y_RST = W'((VISIBLEROWS - SIZE_BALL) / 2);

  logic [W-1:0] xc, yc;
  logic         endframe, frame_go;

  logic [W-1:0] x_q [N_BALLS];
  logic [W-1:0] x_d [N_BALLS];
  logic [W-1:0] y_q [N_BALLS];
  logic [W-1:0] y_d [N_BALLS];
  logic [N_BALLS-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [N_BALLS-1:0] dx_eff, dy_eff, hit;
  logic [W-1:0] speed_q, speed_d;
  logic         inc_pend_q, inc_pend_d, dec_pend_q, dec_pend_d;
  logic         bounce_d, any_coll;
  logic [2:0]   rgb_sel;
  logic [W+1:0] mx [N_BALLS];
  logic [W+1:0] my [N_BALLS];

  assign xc       = RGBStr_i[XC_LO +: W];
  assign yc       = RGBStr_i[0 +: W];
  assign endframe = (xc == W'(VISIBLECOLS - 1)) && (yc == W'(VISIBLEROWS - 1));
  assign frame_go = endframe && !pause;

  // Returns {event, new_dir, new_pos}; the position is clamped to [lo, hi].
  function automatic logic [W+1:0] axis_step(input logic [W-1:0] p, input logic d,
                                             input logic [W-1:0] spd, input logic [W-1:0] lo,
                                             input logic [W-1:0] hi);
    logic [W+1:0] r;
    if (!d) r = (p + spd >= hi) ? {1'b1, 1'b1, hi} : {1'b0, 1'b0, W'(p + spd)};
    else    r = (p < lo + spd)  ? {1'b1, 1'b0, lo} : {1'b0, 1'b1, W'(p - spd)};
    return r;
  endfunction

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? W'(a - b) : W'(b - a);
  endfunction

`ifdef PXS_BALL_COLLIDE_EN
  logic [N_BALLS-1:0] coll;
  always_comb begin
    coll = '0;
    for (int i = 0; i < N_BALLS; i++) begin
      for (int j = i + 1; j < N_BALLS; j++) begin
        if (abs_diff(x_q[i], x_q[j]) < SZ && abs_diff(y_q[i], y_q[j]) < SZ) begin
          coll[i] = 1'b1;
          coll[j] = 1'b1;
        end
      end
    end
  end
  assign dx_eff   = dx_q ^ coll;
  assign dy_eff   = dy_q ^ coll;
  assign any_coll = |coll;
`else
  assign dx_eff   = dx_q;
  assign dy_eff   = dy_q;
  assign any_coll = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
      assign hit[gi] = (xc >= x_q[gi]) && (xc < x_q[gi] + SZ) &&
                       (yc >= y_q[gi]) && (yc < y_q[gi] + SZ);
      assign mx[gi]  = axis_step(x_q[gi], dx_eff[gi], speed_q, X_MIN, X_MAX);
      assign my[gi]  = axis_step(y_q[gi], dy_eff[gi], speed_q, Y_MIN, Y_MAX);
    end
  endgenerate

  // Scan from the highest index down so the lowest-index ball ends up on top.
  always_comb begin
    rgb_sel = RGBStr_i[RGB_LO +: 3];
    for (int i = N_BALLS - 1; i >= 0; i--) begin
      if (hit[i]) rgb_sel = BALL_COLORS[3*i +: 3];
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bounce_d = 1'b0;
    if (frame_go) begin
      bounce_d = any_coll;
      for (int i = 0; i < N_BALLS; i++) begin
        x_d[i]   = mx[i][W-1:0];
        dx_d[i]  = mx[i][W];
        y_d[i]   = my[i][W-1:0];
        dy_d[i]  = my[i][W];
        bounce_d = bounce_d | mx[i][W+1] | my[i][W+1];
      end
    end
  end

  // Speed and request flags update at every frame end, paused or not.
  always_comb begin
    speed_d    = speed_q;
    inc_pend_d = inc_pend_q | inc_vel;
    dec_pend_d = dec_pend_q | dec_vel;
    if (endframe) begin
      if (inc_pend_q && !dec_pend_q && speed_q < W'(MAX_SPEED)) speed_d = speed_q + 1'b1;
      if (dec_pend_q && !inc_pend_q && speed_q > W'(1))         speed_d = speed_q - 1'b1;
      inc_pend_d = inc_vel;
      dec_pend_d = dec_vel;
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      RGBStr_o   <= '0;
      bounce     <= 1'b0;
      speed_q    <= W'(INIT_SPEED);
      inc_pend_q <= 1'b0;
      dec_pend_q <= 1'b0;
      for (int i = 0; i < N_BALLS; i++) begin
        x_q[i]  <= X_RST + W'(2 * SIZE_BALL * i);
        y_q[i]  <= Y_RST;
        dx_q[i] <= i[0];
        dy_q[i] <= i[1];
      end
    end else begin
      RGBStr_o   <= {rgb_sel, RGBStr_i[VGA_HI:0]};
      bounce     <= bounce_d;
      speed_q    <= speed_d;
      inc_pend_q <= inc_pend_d;
      dec_pend_q <= dec_pend_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
    end
  end

endmodule

// File: tb/tb_pxs_multi_ball_overlay.sv
// Randomised scoreboard bench for pxs_multi_ball_overlay against a frame-level ball model.
module tb_pxs_multi_ball_overlay;
  localparam int NB   = 4;
  localparam int S    = 16;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int MAXS = 8;
  localparam int BRD  = 0;
  localparam logic [11:0] COLORS = 12'b011_110_010_101;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] str_i;
  logic        inc_vel, dec_vel, pause;
  logic [25:0] str_o;
  logic        bounce;

  always #5 clk = ~clk;

  pxs_multi_ball_overlay #(
    .N_BALLS(NB), .SIZE_BALL(S), .INIT_SPEED(1), .MAX_SPEED(MAXS), .BORDER(BRD),
    .VISIBLECOLS(COLS), .VISIBLEROWS(ROWS), .BALL_COLORS(COLORS)
  ) dut (
    .px_clk(clk), .rst(rst), .RGBStr_i(str_i), .inc_vel(inc_vel), .dec_vel(dec_vel),
    .pause(pause), .RGBStr_o(str_o), .bounce(bounce)
  );

  typedef struct {
    int          cyc;
    logic [25:0] s;
    logic        b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   done = 0;
  bit   pause_lvl = 0;

  // Ball model: screen coordinates as plain integers, one entry per ball.
  int bx[NB], by[NB], bdx[NB], bdy[NB];
  int spd;
  bit ipend, dpend;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int colour_of(int i);
    logic [11:0] c;
    c = COLORS;
    return int'(c[3*i +: 3]);
  endfunction

  function automatic int pixel_rgb(int xc, int yc, int rin);
    for (int i = 0; i < NB; i++)
      if (xc >= bx[i] && xc < bx[i] + S && yc >= by[i] && yc < by[i] + S) return colour_of(i);
    return rin;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      bx[i]  = (COLS - S) / 4 + 2 * S * i;
      by[i]  = (ROWS - S) / 2;
      bdx[i] = i % 2;
      bdy[i] = (i / 2) % 2;
    end
    spd = 1; ipend = 0; dpend = 0;
  endtask

  task automatic move(inout int p, inout int d, input int lo, input int hi, input int s,
                      inout bit ev);
    if (d == 0) begin
      if (p + s >= hi) begin p = hi; d = 1; ev = 1; end
      else p = p + s;
    end else begin
      if (p < lo + s) begin p = lo; d = 0; ev = 1; end
      else p = p - s;
    end
  endtask

  task automatic frame_end(input bit pz, input bit inc_now, input bit dec_now, output bit ev);
    int s;
    ev = 0;
    s  = spd;
    if (!pz) begin
`ifdef PXS_BALL_COLLIDE_EN
      bit c[NB];
      for (int i = 0; i < NB; i++) c[i] = 0;
      for (int i = 0; i < NB; i++)
        for (int j = i + 1; j < NB; j++)
          if ((bx[i] > bx[j] ? bx[i] - bx[j] : bx[j] - bx[i]) < S &&
              (by[i] > by[j] ? by[i] - by[j] : by[j] - by[i]) < S) begin
            c[i] = 1; c[j] = 1;
          end
      for (int i = 0; i < NB; i++)
        if (c[i]) begin bdx[i] = 1 - bdx[i]; bdy[i] = 1 - bdy[i]; ev = 1; end
`endif
      for (int i = 0; i < NB; i++) begin
        move(bx[i], bdx[i], BRD, COLS - S - BRD, s, ev);
        move(by[i], bdy[i], BRD, ROWS - S - BRD, s, ev);
      end
    end
    if (ipend && !dpend) spd = (spd + 1 > MAXS) ? MAXS : spd + 1;
    else if (dpend && !ipend) spd = (spd - 1 < 1) ? 1 : spd - 1;
    ipend = inc_now;
    dpend = dec_now;
  endtask

  task automatic drv(input int xc, input int yc, input bit r, input bit i_, input bit d_);
    exp_t e;
    int   rgb;
    bit   blank;
    bit   ev;
    @(posedge clk);
    #1;
    rgb     = $urandom_range(0, 7);
    blank   = 1'($urandom_range(0, 1));
    str_i   = {3'(rgb), blank, 11'(xc), 11'(yc)};
    rst     = r;
    inc_vel = i_;
    dec_vel = d_;
    pause   = pause_lvl;
    e.cyc   = cyc;
    e.b     = 1'b0;
    if (r) begin
      e.s = '0;
      model_reset();
    end else begin
      e.s = {3'(pixel_rgb(xc, yc, rgb)), blank, 11'(xc), 11'(yc)};
      if (xc == COLS - 1 && yc == ROWS - 1) begin
        frame_end(pause_lvl, i_, d_, ev);
        e.b = ev;
      end else begin
        ipend = ipend | i_;
        dpend = dpend | d_;
      end
    end
    q.push_back(e);
  endtask

  // Pixel that never coincides with the frame-end coordinate.
  task automatic pick_pixel(input int k, output int xc, output int yc);
    int b, v;
    if (k < 2 * NB) begin
      b = k % NB;
      v = $urandom_range(0, 3);
      case (v)
        0: begin xc = bx[b];         yc = by[b];         end
        1: begin xc = bx[b] + S - 1; yc = by[b] + S - 1; end
        2: begin xc = bx[b] + S;     yc = by[b] + $urandom_range(0, S - 1); end
        default: begin
          xc = bx[b] + $urandom_range(0, S + 3) - 2;
          yc = by[b] + $urandom_range(0, S + 3) - 2;
        end
      endcase
      if (xc < 0) xc = 0;
      if (yc < 0) yc = 0;
    end else begin
      xc = $urandom_range(0, COLS - 1);
      yc = $urandom_range(0, ROWS - 1);
    end
    if (xc == COLS - 1 && yc == ROWS - 1) xc = COLS - 2;
  endtask

  task automatic run_frame(input int npx, input int n_inc, input int n_dec,
                           input bit inc_end, input bit dec_end);
    int xc, yc;
    for (int k = 0; k < npx; k++) begin
      pick_pixel(k, xc, yc);
      drv(xc, yc, 0, k < n_inc, k < n_dec);
    end
    drv(COLS - 1, ROWS - 1, 0, inc_end, dec_end);
  endtask

  // Scoreboard monitor: one comparison per output cycle, sampled on the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_checks++;
        if (str_o === e.s && bounce === e.b) n_pass++;
        else $display("FAIL px_out cyc=%0d got stream=%h bounce=%b want stream=%h bounce=%b",
                      e.cyc, str_o, bounce, e.s, e.b);
      end
      if (done) begin
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int xc, yc;
    rst = 1'b1; str_i = '0; inc_vel = 1'b0; dec_vel = 1'b0; pause = 1'b0;
    model_reset();
    drv(0, 0, 1, 0, 0);
    drv(0, 0, 1, 0, 0);
    // Reset picture: ball0 at (156,232), ball1 at (188,232).
    drv(156, 232, 0, 0, 0);
    drv(172, 232, 0, 0, 0);
    drv(188, 232, 0, 0, 0);
    drv(171, 247, 0, 0, 0);
    run_frame(10, 0, 0, 0, 0);
    // Speed saturation up, down, then simultaneous requests.
    for (int f = 0; f < 10; f++) run_frame(10, 1, 0, 0, 0);
    for (int f = 0; f < 10; f++) run_frame(10, 0, 1, 0, 0);
    run_frame(10, 1, 1, 0, 0);
    run_frame(10, 0, 0, 1, 0);
    run_frame(10, 0, 0, 0, 0);
    // Pause for three frames with a pending increment.
    pause_lvl = 1;
    run_frame(10, 1, 0, 0, 0);
    run_frame(10, 0, 0, 0, 0);
    run_frame(10, 0, 0, 0, 0);
    pause_lvl = 0;
    run_frame(10, 0, 0, 0, 0);
    // Mid-frame reset at pixel (300,100).
    drv(10, 20, 0, 1, 0);
    drv(300, 100, 1, 0, 0);
    run_frame(10, 0, 0, 0, 0);
    for (int f = 0; f < 1200; f++) begin
      pause_lvl = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        pick_pixel(2 * NB, xc, yc);
        drv(xc, yc, 1, 0, 0);
      end
      run_frame($urandom_range(2 * NB, 2 * NB + 6),
                ($urandom_range(0, 9) < 3) ? 1 : 0,
                ($urandom_range(0, 9) < 3) ? 1 : 0,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
    end
    pause_lvl = 0;
    drv(5, 5, 0, 0, 0);
    repeat (3) @(posedge clk);
    done = 1;
  end

endmodule
